// File: rtl/mips_dbus_responder.sv
// -----------------------------------------------------------------------------
// mips_dbus_responder
//
// Data-side bus responder for the single-cycle MIPS core. It serves the core's
// load/store port with a word-addressed RAM and a small MMIO window. The window
// holds a TX FIFO drained by a valid/ready consumer, a STATUS register and a
// free-running CYCLE counter.
//
// Loads are combinational so the core finishes a load in one cycle. Stores
// commit on the rising edge of clk.
//
// Parameters
//   RAM_WORDS   number of 32-bit RAM words (power of two, 4..1024)
//   FIFO_DEPTH  TX FIFO entries (power of two, 2..64)
//
// Ports
//   clk        sole clock, rising edge
//   reset      async active-high; clears all MMIO state (RAM is kept)
//   memwrite   store strobe from the core
//   addr       byte address; addr[1:0] ignored
//   writedata  store data
//   readdata   load data, combinational from addr and current state
//   tx_valid   FIFO non-empty
//   tx_data    FIFO head entry, 0 when empty
//   tx_ready   consumer takes the head when tx_valid & tx_ready at the edge
//
// Memory map
//   0x0000_0000 .. RAM_WORDS*4-1   RAM
//   0xFFFF_FFF0  TXDATA   W: push writedata        R: 0
//   0xFFFF_FFF4  STATUS   W: wd[2]=1 clears ovf    R: {count@[14:8], ovf, empty, full}
//   0xFFFF_FFF8  CYCLE    W: load writedata        R: counter value
//   0xFFFF_FFFC  reserved W: ignored               R: 0
//   anything else         W: ignored               R: 0
// -----------------------------------------------------------------------------
module mips_dbus_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [31:0]      RAM_BYTES     = 32'(RAM_WORDS * 4);
    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLE  = 2'd2;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              sel_ram;
    logic              sel_mmio;
    logic [1:0]        reg_sel;
    logic [RAM_AW-1:0] ram_idx;

    assign sel_ram  = (addr < RAM_BYTES);
    assign sel_mmio = (addr[31:4] == 28'hFFF_FFFF);
    assign reg_sel  = addr[3:2];
    assign ram_idx  = addr[RAM_AW+1:2];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      ram_q  [RAM_WORDS];
    logic [31:0]      fifo_q [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic [31:0]      cycle_q,  cycle_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic        ram_we;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        drop;
    logic        ovf_clr;
    logic        cycle_ld;
    logic        fifo_full;
    logic        fifo_empty;

    always_comb begin
        fifo_full  = (count_q == FIFO_FULL_CNT);
        fifo_empty = (count_q == '0);

        ram_we   = memwrite & sel_ram;
        push_req = memwrite & sel_mmio & (reg_sel == REG_TXDATA);
        ovf_clr  = memwrite & sel_mmio & (reg_sel == REG_STATUS) & writedata[2];
        cycle_ld = memwrite & sel_mmio & (reg_sel == REG_CYCLE);

        pop  = ~fifo_empty & tx_ready;
        // A pop in the same edge frees the slot, so a push into a full FIFO
        // is still accepted and lands at the tail.
        push = push_req & (~fifo_full | pop);
        drop = push_req & fifo_full & ~pop;

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A fresh overflow outranks a clear arriving in the same edge.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        cycle_d = cycle_ld ? writedata : cycle_q + 32'd1;
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cycle_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cycle_q  <= cycle_d;
        end
    end

    // RAM and FIFO storage carry no reset. FIFO slots are invisible once the
    // count returns to zero, which is enough to discard them on reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= writedata;
        end
        if (push) begin
            fifo_q[wr_ptr_q] <= writedata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [31:0] status;

    always_comb begin
        status             = '0;
        status[0]          = fifo_full;
        status[1]          = fifo_empty;
        status[2]          = ovf_q;
        status[8 +: CNT_W] = count_q;
    end

    always_comb begin
        readdata = '0;
        if (sel_ram) begin
            readdata = ram_q[ram_idx];
        end else if (sel_mmio) begin
            case (reg_sel)
                REG_STATUS: readdata = status;
                REG_CYCLE:  readdata = cycle_q;
                default:    readdata = '0;
            endcase
        end
    end

    // These depend on registered state only, never on tx_ready.
    assign tx_valid = ~fifo_empty;
    assign tx_data  = fifo_empty ? 32'd0 : fifo_q[rd_ptr_q];

endmodule

// File: doc/mips_dbus_responder.md
# mips_dbus_responder

Data-side bus responder for the single-cycle MIPS core: it answers the core's load/store port (`memwrite`, address from `aluout`, `writedata`, `readdata`). It holds a word-addressed data RAM plus a small memory-mapped I/O window: a transmit FIFO drained by an external valid/ready consumer, a status register, and a free-running cycle counter. Reads are combinational so the core completes a load in its single cycle. Writes commit on the rising clock edge.

## Interface
- `RAM_WORDS`, 64: number of 32-bit RAM words; power of two, 4..1024.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..64.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all MMIO state immediately.
- `memwrite`  in  1  store strobe from the core, sampled at the rising edge.
- `addr`  in  32  byte address (core `aluout`); `addr[1:0]` ignored.
- `writedata`  in  32  store data.
- `readdata`  out  32  load data; combinational function of `addr` and current state.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_data`  out  32  FIFO head entry; 0 when empty.
- `tx_ready`  in  1  consumer accepts the head when `tx_valid & tx_ready` at the rising edge.

## Operation
- Address decode, one region per access:
  - RAM: `addr < RAM_WORDS*4`, word index `addr[log2(RAM_WORDS)+1:2]`.
  - MMIO: `addr[31:4] == 28'hFFFFFFF`; register select is `addr[3:2]`.
  - Unmapped: all other addresses. Reads return 0; writes are ignored.
- RAM:
  - Store writes the full word.
  - RAM is not cleared by reset. Contents after reset are undefined until written.
- MMIO registers:
  - `0xFFFFFFF0` TXDATA. Write: push `writedata`. Read: returns 0.
  - `0xFFFFFFF4` STATUS. Read format:
    - bit0 full
    - bit1 empty
    - bit2 overflow (sticky)
    - bits[14:8] count (zero-extended)
    - other bits 0
  - STATUS write: `writedata[2]=1` clears overflow; all other bits are ignored.
  - `0xFFFFFFF8` CYCLE. Read: current counter value. Write: loads `writedata`.
  - `0xFFFFFFFC` reserved. Reads return 0; writes are ignored.
- TX FIFO:
  - Circular buffer with read pointer, write pointer and a `count` register of width log2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop: `tx_valid & tx_ready`. Head advances, count decrements.
  - Push: TXDATA write, accepted iff `count < FIFO_DEPTH`, or a pop occurs in the same cycle.
  - Simultaneous push and pop: count unchanged; the pushed word lands at the tail.
  - Push while full with no pop: data dropped, count unchanged, overflow set to 1.
  - If a STATUS clear and a new overflow occur in the same cycle, the new overflow wins (overflow=1).
  - Pop while empty is impossible, since `tx_valid=0`.
- CYCLE counter:
  - Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - A CYCLE write loads `writedata` at that edge instead of incrementing. The next cycle continues from the loaded value plus 1.

## Timing
- Reset (asynchronous assert) values:
  - count=0, pointers=0, overflow=0, CYCLE=0
  - `tx_valid=0`, `tx_data=0`
  - `readdata` reflects these values combinationally.
- Reset deassertion: the first rising edge with `reset=0` performs normal updates; CYCLE reads 1 after that edge.
- Reset asserted mid-operation: FIFO contents are discarded, pending push/pop is lost, RAM is untouched.
- Load latency: 0 cycles (combinational `addr` -> `readdata`). Store latency: 1 edge.
  - A read of a location in the same cycle as a write to it returns the old value.
  - The new value is visible after the edge.
- FIFO latency:
  - A word pushed at edge N is visible on `tx_data` with `tx_valid=1` after edge N (when the FIFO was empty).
  - STATUS count reflects the post-edge value.
- `tx_valid` and `tx_data` are pure functions of registered state; neither depends combinationally on `tx_ready`.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 and load 0x10 → `readdata=0xDEADBEEF`. Load 0x13 returns the same word (low bits ignored). Load 0x4000 (unmapped) → 0.
- With `tx_ready=0`, push 0x1..0x8 to TXDATA → STATUS=0x0801 (count 8, full). A 9th push of 0x9 → STATUS=0x0805 (overflow set). Then `tx_ready=1` → drains 0x1..0x8 in order; final STATUS=0x0006 (empty, overflow still set).
- Write 0x4 to STATUS → overflow cleared, STATUS=0x0002. In the same cycle as a dropped push (full, no pop), a clear → overflow remains 1.
- FIFO full with `tx_ready=1`, push 0xA in the same cycle → accepted, count stays 8, 0xA emerges last; the pointer-wrap path is exercised.
- Write 0xFFFFFFFE to CYCLE → reads 0xFFFFFFFE next cycle, then 0xFFFFFFFF, then 0x00000000.
- Assert `reset` asynchronously between edges with 3 entries queued → `tx_valid` falls immediately, STATUS=0x0002, CYCLE=0; a previously stored RAM word reads back unchanged.
